// File: rtl/apb3_bridge_pkg.sv
// Shared types for the APB3 bridge: FSM state encoding and the buffered request.
package apb3_bridge_pkg;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;
  localparam int REQ_SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
    logic [REQ_SEL_W-1:0]  sel;
  } apb_req_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles with PREADY low; expired_o flags the count reaching TIMEOUT_CYC.
module apb_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic Hclk,
  input  logic Hresetn,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at CNT_MAX so a zero timeout keeps the counter parked at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                         cnt_d = '0;
    else if (inc_i && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expired_o = (TIMEOUT_CYC != 0) && (cnt_q == CNT_MAX);

endmodule

// File: rtl/apb3_bridge_ctrl.sv
// Request/response to APB3 master bridge with a one-entry request buffer,
// back-to-back transfers, decode-error and PREADY timeout handling.
module apb3_bridge_ctrl
  import apb3_bridge_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLV     = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_sel,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] Paddr,
  output logic              Pwrite,
  output logic [DATA_W-1:0] Pwdata,
  output logic [NUM_SLV-1:0] Pselx,
  output logic              Penable,
  input  logic              Pready,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pslverr
);

  apb_state_e        state_q;
  apb_req_t          buf_q, buf_d;
  logic              buf_full_q, buf_full_d, req_ready_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q, rsp_rdata_q;
  logic [NUM_SLV-1:0] pselx_q;
  logic              pwrite_q, penable_q, rsp_valid_q, rsp_err_q;
  logic              accept, sel_ok, done, launch, drain, tmo;

  always_comb begin
    accept = req_valid && req_ready_q;
    sel_ok = int'(buf_q.sel) < NUM_SLV;
    done   = (state_q == ACCESS) && (Pready || tmo);
    launch = buf_full_q && sel_ok && ((state_q == IDLE) || done);
    // A bad select only drains from IDLE, so its error pulse never collides
    // with a completion pulse.
    drain  = launch || (buf_full_q && !sel_ok && (state_q == IDLE));
    buf_d  = '{write: req_write, addr: REQ_ADDR_W'(req_addr),
               wdata: REQ_DATA_W'(req_wdata), sel: req_sel};
    buf_full_d = buf_full_q;
    if (accept)     buf_full_d = 1'b1;
    else if (drain) buf_full_d = 1'b0;
  end

  apb_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .clr_i     (launch),
    .inc_i     ((state_q == ACCESS) && !Pready),
    .expired_o (tmo)
  );

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      req_ready_q <= 1'b1;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pselx_q     <= '0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      buf_full_q  <= buf_full_d;
      req_ready_q <= ~buf_full_d;
      if (accept) buf_q <= buf_d;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (buf_full_q && !sel_ok) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (done) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= Pready ? Pslverr : 1'b1;
            rsp_rdata_q <= (Pready && !pwrite_q) ? Prdata : '0;
            state_q     <= IDLE;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (launch) begin
        state_q   <= SETUP;
        paddr_q   <= ADDR_W'(buf_q.addr);
        pwrite_q  <= buf_q.write;
        pwdata_q  <= DATA_W'(buf_q.wdata);
        pselx_q   <= NUM_SLV'(1) << buf_q.sel;
        penable_q <= 1'b0;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign Paddr     = paddr_q;
  assign Pwrite    = pwrite_q;
  assign Pwdata    = pwdata_q;
  assign Pselx     = pselx_q;
  assign Penable   = penable_q;

endmodule

// File: tb/tb_apb3_bridge_ctrl.sv
// Directed bench for apb3_bridge_ctrl with default parameters.
module tb_apb3_bridge_ctrl;

  logic        Hclk = 1'b0, Hresetn = 1'b0;
  logic        req_valid = 0, req_write = 0, req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_sel = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, Paddr, Pwdata;
  logic        Pwrite, Penable;
  logic [2:0]  Pselx;
  logic        Pready = 0, Pslverr = 0;
  logic [31:0] Prdata = '0;

  int n_chk = 0, n_fail = 0;

  apb3_bridge_ctrl dut (
    .Hclk(Hclk), .Hresetn(Hresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Paddr(Paddr), .Pwrite(Pwrite), .Pwdata(Pwdata), .Pselx(Pselx),
    .Penable(Penable), .Pready(Pready), .Prdata(Prdata), .Pslverr(Pslverr)
  );

  always #5 Hclk = ~Hclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Hclk);
    @(negedge Hclk);
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] s);
    check("push_ready", req_ready, 1);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_sel = s;
    cyc();
    req_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    #1;
    check("rst_penable", Penable, 0);
    check("rst_pselx", Pselx, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_paddr", Paddr, 0);
    repeat (2) @(negedge Hclk);
    Hresetn = 1;
    cyc();
    check("rst_ready", req_ready, 1);

    // Single read, immediate PREADY
    push(0, 32'h10, 0, 3'd1);
    cyc();
    check("t1_setup_pselx", Pselx, 3'b010);
    check("t1_setup_penable", Penable, 0);
    check("t1_setup_paddr", Paddr, 32'h10);
    Pready = 1; Prdata = 32'hA5A5_0001;
    cyc();
    check("t1_access_penable", Penable, 1);
    check("t1_access_rsp", rsp_valid, 0);
    cyc();
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rdata", rsp_rdata, 32'hA5A5_0001);
    check("t1_err", rsp_err, 0);
    check("t1_idle_pselx", Pselx, 0);
    check("t1_idle_penable", Penable, 0);
    Pready = 0;
    cyc();
    check("t1_pulse_once", rsp_valid, 0);

    // Write then a read queued during the write's transfer: back-to-back
    push(1, 32'h20, 32'hDEAD_BEEF, 3'd0);
    cyc();
    check("t2_w_paddr", Paddr, 32'h20);
    check("t2_w_pselx", Pselx, 3'b001);
    check("t2_w_pwrite", Pwrite, 1);
    check("t2_w_pwdata", Pwdata, 32'hDEAD_BEEF);
    push(0, 32'h30, 0, 3'd2);
    check("t2_access_penable", Penable, 1);
    check("t2_access_paddr", Paddr, 32'h20);
    check("t2_buf_full_ready", req_ready, 0);
    Pready = 1; Prdata = 32'h1234_5678;
    cyc();
    check("t2_w_rsp", rsp_valid, 1);
    check("t2_w_rdata_zero", rsp_rdata, 0);
    check("t2_b2b_penable", Penable, 0);
    check("t2_b2b_paddr", Paddr, 32'h30);
    check("t2_b2b_pselx", Pselx, 3'b100);
    check("t2_b2b_pwrite", Pwrite, 0);
    cyc();
    check("t2_r_penable", Penable, 1);
    check("t2_r_no_rsp", rsp_valid, 0);
    cyc();
    check("t2_r_rsp", rsp_valid, 1);
    check("t2_r_rdata", rsp_rdata, 32'h1234_5678);
    check("t2_r_pselx", Pselx, 0);
    Pready = 0;

    // Three wait states, then slave error
    push(0, 32'h40, 0, 3'd1);
    Prdata = 32'hCAFE_0003;
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) begin
      check("t3_penable", Penable, 1);
      check("t3_paddr", Paddr, 32'h40);
      check("t3_pselx", Pselx, 3'b010);
      check("t3_no_rsp", rsp_valid, 0);
      if (i == 3) begin Pready = 1; Pslverr = 1; end
      cyc();
    end
    check("t3_rsp", rsp_valid, 1);
    check("t3_err", rsp_err, 1);
    check("t3_rdata", rsp_rdata, 32'hCAFE_0003);
    check("t3_penable_off", Penable, 0);
    Pready = 0; Pslverr = 0;

    // Timeout: 16 tolerated wait cycles, aborted on the 17th
    push(0, 32'h50, 0, 3'd0);
    cyc();
    cyc();
    n = 0;
    while (!rsp_valid && n < 40) begin cyc(); n++; end
    check("t4_tmo_cycles", n, 17);
    check("t4_tmo_err", rsp_err, 1);
    check("t4_tmo_rdata", rsp_rdata, 0);
    check("t4_tmo_pselx", Pselx, 0);
    check("t4_tmo_penable", Penable, 0);
    cyc();
    push(0, 32'h54, 0, 3'd0);
    cyc();
    cyc();
    repeat (16) cyc();
    check("t4_edge_penable", Penable, 1);
    check("t4_edge_no_rsp", rsp_valid, 0);
    Pready = 1; Prdata = 32'h5555_AAAA;
    cyc();
    check("t4_edge_rsp", rsp_valid, 1);
    check("t4_edge_err", rsp_err, 0);
    check("t4_edge_rdata", rsp_rdata, 32'h5555_AAAA);
    Pready = 0;

    // Decode error
    push(0, 32'h60, 0, 3'd5);
    check("t5_no_pselx", Pselx, 0);
    cyc();
    check("t5_rsp", rsp_valid, 1);
    check("t5_err", rsp_err, 1);
    check("t5_rdata", rsp_rdata, 0);
    check("t5_pselx", Pselx, 0);
    cyc();
    check("t5_pulse_once", rsp_valid, 0);
    check("t5_ready", req_ready, 1);

    // Reset mid-ACCESS with the buffer full
    push(1, 32'h70, 32'h0BAD_F00D, 3'd2);
    cyc();
    push(0, 32'h74, 0, 3'd0);
    check("t6_pre_penable", Penable, 1);
    check("t6_pre_ready", req_ready, 0);
    #2 Hresetn = 0;
    #1;
    check("t6_rst_penable", Penable, 0);
    check("t6_rst_pselx", Pselx, 0);
    check("t6_rst_paddr", Paddr, 0);
    check("t6_rst_pwdata", Pwdata, 0);
    check("t6_rst_pwrite", Pwrite, 0);
    check("t6_rst_rsp", rsp_valid, 0);
    @(negedge Hclk);
    @(negedge Hclk);
    Hresetn = 1;
    seen = 0;
    repeat (6) begin
      cyc();
      if (rsp_valid || Pselx != 0) seen = 1;
    end
    check("t6_no_rsp_after", seen, 0);
    check("t6_ready", req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
